// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin ownership arbiter that drives the 8:1 mux select, with a hold timeout
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       lock,
  input  logic       enable,
  output logic [7:0] gnt,
  output logic [2:0] sel,
  output logic       sel_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [7:0] MH = 8'(MAX_HOLD);
  state_t st;
  logic [2:0] ptr, base, w_idx;
  logic [7:0] hcnt;
  logic own_req, cont, forced, w_ok;
  // first requester after p, wrapping, so p itself is scanned last
  function automatic logic [3:0] win(input logic [7:0] r, input logic [2:0] p);
    logic [3:0] w;
    logic [2:0] i;
    w = '0;
    for (int k = 8; k >= 1; k--) begin
      i = p + 3'(k);
      if (r[i]) w = {1'b1, i};
    end
    return w;
  endfunction
  always_comb begin
    own_req = req[sel];
    cont = st == BUSY && own_req && (hcnt < MH || lock);
    forced = st == BUSY && own_req && !lock && hcnt >= MH;
    base = st == BUSY ? sel : ptr;
    {w_ok, w_idx} = win(req, base);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= IDLE;
      gnt <= '0;
      sel <= '0;
      sel_valid <= 1'b0;
      timeout <= 1'b0;
      ptr <= 3'd7;
      hcnt <= '0;
    end else begin
      timeout <= forced;
      if (cont) begin
        hcnt <= hcnt < MH ? hcnt + 8'd1 : hcnt;
      end else begin
        if (st == BUSY) ptr <= sel;
        if (enable && w_ok) begin
          st <= BUSY;
          gnt <= 8'd1 << w_idx;
          sel <= w_idx;
          sel_valid <= 1'b1;
          hcnt <= 8'd1;
        end else begin
          st <= IDLE;
          gnt <= '0;
          sel_valid <= 1'b0;
          hcnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// tb_mux8_rr_arbiter: table vectors, directed corner sequences and random traffic against an ownership model
module tb_mux8_rr_arbiter;
  localparam int MH = 8;
  logic clk = 1'b0, rst_n = 1'b0, lock = 1'b0, enable = 1'b1;
  logic [7:0] req = '0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic sel_valid, timeout;
  int n_tests = 0, n_fail = 0;
  int m_own, m_h, m_ptr, m_sel;
  logic m_to;

  typedef struct {
    logic [7:0] req;
    logic lock, en;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic v, to;
  } vec_t;
  vec_t tbl[13];

  mux8_rr_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .enable(enable),
    .gnt(gnt), .sel(sel), .sel_valid(sel_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n) assert (!$isunknown(req)) else $error("req carries X");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int winner(input logic [7:0] r, input int p);
    for (int d = 1; d <= 8; d++) if (r[(p + d) % 8]) return (p + d) % 8;
    return -1;
  endfunction

  task automatic model_reset();
    m_own = -1; m_h = 0; m_ptr = 7; m_sel = 0; m_to = 1'b0;
  endtask

  // an ownership either continues, or ends and the next owner is picked right away
  task automatic model_step(input logic [7:0] r, input logic lk, input logic en);
    int w;
    m_to = 1'b0;
    if (m_own >= 0) begin
      if (r[m_own] && (m_h < MH || lk)) begin
        m_h = (m_h + 1 > MH) ? MH : m_h + 1;
        return;
      end
      m_to = r[m_own] && !lk;
      m_ptr = m_own;
      m_own = -1;
    end
    w = en ? winner(r, m_ptr) : -1;
    if (w >= 0) begin
      m_own = w; m_h = 1; m_sel = w;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(req, lock, enable);
    #1;
    chk("gnt", 32'(gnt), m_own >= 0 ? 32'(1) << m_own : 32'(0));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("sel_valid", 32'(sel_valid), 32'(m_own >= 0));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; lock = 1'b0; enable = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{8'hFF, 1'b0, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[8]  = '{8'hFF, 1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b1};
    tbl[9]  = '{8'h00, 1'b0, 1'b1, 8'h00, 3'd1, 1'b0, 1'b0};
    tbl[10] = '{8'h84, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0};
    tbl[11] = '{8'h84, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
    tbl[12] = '{8'h84, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0};
    model_reset();
    #2;
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_sel", 32'(sel), 0);
    chk("reset_valid", 32'(sel_valid), 0);
    chk("reset_timeout", 32'(timeout), 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req; lock = tbl[i].lock; enable = tbl[i].en;
      tick();
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_valid", i), 32'(sel_valid), 32'(tbl[i].v));
      chk($sformatf("tbl%0d_timeout", i), 32'(timeout), 32'(tbl[i].to));
    end

    // sources 2 and 7 alternate every MAX_HOLD cycles with no idle gap
    do_reset();
    req = 8'h84;
    for (int i = 0; i < 4 * MH; i++) begin
      tick();
      chk("alt_owner", 32'(gnt), (i / MH) % 2 == 0 ? 32'h04 : 32'h80);
      chk("alt_timeout", 32'(timeout), 32'(i > 0 && i % MH == 0));
    end

    // voluntary release by 3 hands straight to 5 without timeout
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h28;
    tick();
    req = 8'h20;
    tick();
    chk("vol_gnt", 32'(gnt), 32'h20);
    chk("vol_timeout", 32'(timeout), 0);
    // ptr now 3: simultaneous 4 and 2 favour 4
    do_reset();
    req = 8'h08;
    tick();
    tick();
    req = 8'h14;
    tick();
    chk("ptr3_gnt", 32'(gnt), 32'h10);

    // lock exempts the owner from timeout until it drops
    do_reset();
    req = 8'h40; lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("lock_gnt", 32'(gnt), 32'h40);
      chk("lock_timeout", 32'(timeout), 0);
    end
    lock = 1'b0; req = 8'h42;
    tick();
    chk("unlock_gnt", 32'(gnt), 32'h02);
    chk("unlock_timeout", 32'(timeout), 1);

    // enable gates new ownership only
    do_reset();
    enable = 1'b0; req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dis_gnt", 32'(gnt), 0);
    end
    enable = 1'b1;
    tick();
    chk("en_gnt", 32'(gnt), 32'h10);
    enable = 1'b0;
    for (int i = 0; i < MH + 2; i++) tick();
    chk("dis_idle", 32'(sel_valid), 0);

    // asynchronous reset mid-ownership, then re-arbitration from ptr=7
    do_reset();
    req = 8'h20;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_gnt", 32'(gnt), 0);
    chk("async_sel", 32'(sel), 0);
    chk("async_valid", 32'(sel_valid), 0);
    req = 8'hA0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_gnt", 32'(gnt), 32'h20);
    chk("post_rst_sel", 32'(sel), 5);

    // random traffic, requests held for stretches to exercise timeouts
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = 8'($urandom) & 8'($urandom);
      lock = $urandom_range(0, 9) == 0;
      enable = $urandom_range(0, 7) != 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin scheduler that shares the 8-input, 1-bit-per-lane select-mux datapath among 8 requesters.
- Produces the 3-bit select code (sel[0]→S0, sel[1]→S1, sel[2]→S2 of the mux bank) and a one-hot grant.
- Holds ownership while the owner keeps requesting, bounded by a hold timeout.
- Sits between requesting units (e.g. shared write-back/bus sources) and the mux bank that steers the shared resource.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per ownership before forced release (legal 1..255).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  request per requester; bit i = source i (mux input Di)
- lock  input  1  when high, the current owner is exempt from the MAX_HOLD timeout
- enable  input  1  when low, no new ownership is started; the current owner finishes normally
- gnt  output  8  one-hot grant, all-zero when idle
- sel  output  3  binary index of owner; drives mux S2..S0
- sel_valid  output  1  high when gnt is non-zero
- timeout  output  1  one-cycle pulse on the edge a forced release occurs

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - gnt=0, sel=0, sel_valid=0, timeout=0
  - priority pointer ptr=7, so requester 0 has top priority first
  - hold counter hcnt=0, state IDLE
- All outputs are registered. sel and gnt always agree: sel=i exactly when gnt=(1<<i).
- Winner function W(req, p): the first set bit of req scanning p+1, p+2, …, wrapping modulo 8. No bit set → no winner.
- State IDLE:
  - On an edge where enable=1 and req≠0: gnt←one-hot(W(req,ptr)), sel←W, sel_valid←1, hcnt←1, go to BUSY.
  - Latency: req sampled at edge N → grant visible after edge N.
  - enable=0 or req=0: stay IDLE; sel keeps its last value; sel_valid=0.
- State BUSY, owner o:
  - Continue: req[o]=1 and (hcnt<MAX_HOLD or lock=1). Hold the grant; hcnt←hcnt+1, saturating at MAX_HOLD.
  - Voluntary release: req[o]=0.
  - Forced release: req[o]=1, lock=0 and hcnt==MAX_HOLD. timeout←1 for that cycle only.
  - On any release edge, ptr←o, then arbitrate in the same edge (no bubble):
    - If enable=1 and W(req,o) exists, grant it and set hcnt←1.
    - The timed-out owner is last in scan order, so it is re-granted only if it is the sole requester. That re-grant still pulses timeout, and hcnt restarts at 1.
    - Otherwise gnt←0, sel_valid←0, go to IDLE.
- ptr updates only on release, never while holding.
- enable deasserted mid-ownership does not revoke the grant.
- Requests from non-owners never preempt the owner.
- lock is sampled every cycle. If lock drops while hcnt≥MAX_HOLD and req[o]=1, forced release happens on that edge.
- MAX_HOLD=1: every ownership lasts exactly one cycle unless lock=1. This gives pure per-cycle round-robin.
- rst_n asserted mid-ownership: outputs clear immediately (asynchronous); ptr returns to 7.
- req bits for sources with no pending work must be 0. X on req is not tolerated (checked by assertion in the bench).
- Sequencing is implemented with small counters/registers.

Test Plan:
- Reset with req=8'hFF, release rst_n → after first edge gnt=8'h01, sel=0, sel_valid=1. Hold req → release at hcnt=8 with timeout pulse, gnt=8'h02, sel=1.
- req=8'b1000_0100 held steady, MAX_HOLD=8 → grants alternate between sources 2 and 7, 8 cycles each, no idle cycle between owners, timeout pulsing at each handover.
- Owner 3 drops req after 2 cycles while req[5]=1 → on that edge gnt=8'h20, sel=5, timeout=0. ptr=3 afterwards; a later simultaneous req[4] and req[2] grants 4 first.
- lock=1 with sole requester 6 for 20 cycles → gnt=8'h40 throughout, timeout never pulses. Drop lock at cycle 20 with req[1]=1 → next edge gnt=8'h02, timeout=1.
- enable=0, req=8'h10 → gnt stays 0, sel_valid=0. Raise enable → grant 4 after next edge. Drop enable mid-grant → owner keeps its grant until release, then IDLE.
- Assert rst_n low mid-grant of source 5 → gnt=0, sel=0, sel_valid=0 immediately without a clock edge. Release with req=8'hA0 → source 5 granted first (ptr=7 scan: 0..5).
